// File: rtl/bus_decoder.sv
// Single-master address decoder with a small transfer FSM (IDLE/ACCESS/RESP/ERROR).
// The request is latched on acceptance and one slave selected by address match.
// The first error address is captured in a sticky fault register.
// Optional build macro: BUS_DECODER_TIMEOUT_EN adds an 8-bit slave wait timeout.
module bus_decoder #(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned DATA_W   = 32,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE =
        {32'hF000_0010, 32'hF000_0000, 32'h0000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hF000_0000, 32'h0000_0000},
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    // master side
    input  logic                       req,
    input  logic                       we,
    input  logic [31:0]                a,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ack,
    output logic                       err,
    // slave side
    output logic [N_SLAVES-1:0]        s_sel,
    output logic [N_SLAVES-1:0]        s_we,
    output logic [31:0]                s_a,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_ack,
    // fault capture
    output logic                       fault,
    output logic [31:0]                fault_addr,
    input  logic                       fault_clr
);

    localparam int unsigned IdxW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fault_q;
    logic [31:0]       fault_addr_q;

    logic              hit;
    logic [IdxW-1:0]   hit_idx;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;
    logic              err_entry;
    logic [31:0]       err_addr;

    // Address match; descending scan so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((SLAVE_MASK[i*32 +: 32] != 32'h0) &&
                ((a & SLAVE_MASK[i*32 +: 32]) ==
                 (SLAVE_BASE[i*32 +: 32] & SLAVE_MASK[i*32 +: 32]))) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
    end

    // Pick the selected slave's ack and read data; other slaves are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_DECODER_TIMEOUT_EN
    logic [7:0] cnt_q;

    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    // Wait counter: cleared on ACCESS entry, counts ACCESS cycles without ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q != StAccess) begin
            cnt_q <= '0;
        end else if (!sel_ack) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // Next-state logic; a slave ack wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = hit ? StAccess : StError;
                end
            end
            StAccess: begin
                if (sel_ack) begin
                    state_d = StResp;
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StResp:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Fault address comes straight from the bus when the error is decided in IDLE.
    assign err_entry = (state_d == StError) && (state_q != StError);
    assign err_addr  = (state_q == StIdle) ? a : addr_q;

    // State register and request latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                idx_q   <= hit_idx;
                we_q    <= we;
                addr_q  <= a;
                wdata_q <= wdata;
            end
            if (state_q == StAccess && sel_ack && !we_q) begin
                rdata_q <= sel_rdata;
            end
        end
    end

    // Sticky fault flag; a new fault beats a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else if (err_entry) begin
            fault_q <= 1'b1;
            if (!fault_q || fault_clr) begin
                fault_addr_q <= err_addr;
            end
        end else if (fault_clr) begin
            fault_q <= 1'b0;
        end
    end

    // Output decode from the current state.
    always_comb begin
        s_sel = '0;
        s_we  = '0;
        if (state_q == StAccess) begin
            s_sel[idx_q] = 1'b1;
            s_we[idx_q]  = we_q;
        end
    end

    assign s_a        = addr_q;
    assign s_wdata    = wdata_q;
    assign ack        = (state_q == StResp) || (state_q == StError);
    assign err        = (state_q == StError);
    assign rdata      = (state_q == StError) ? '0 : rdata_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule
